// File: rtl/gb_cpu_common_pkg.sv
// gb_cpu_common_pkg: shared CPU types - ALU flags, register/pair selects, DMG post-boot constants
package gb_cpu_common_pkg;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef enum logic [2:0] {
        REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_F, REG_A
    } reg8_sel_t;

    typedef enum logic [2:0] {
        PAIR_BC, PAIR_DE, PAIR_HL, PAIR_SP, PAIR_AF, PAIR_PC
    } reg16_sel_t;

    localparam logic [7:0]  BOOT_A  = 8'h01;
    localparam logic [7:0]  BOOT_F  = 8'hB0;
    localparam logic [7:0]  BOOT_B  = 8'h00;
    localparam logic [7:0]  BOOT_C  = 8'h13;
    localparam logic [7:0]  BOOT_D  = 8'h00;
    localparam logic [7:0]  BOOT_E  = 8'hD8;
    localparam logic [7:0]  BOOT_H  = 8'h01;
    localparam logic [7:0]  BOOT_L  = 8'h4D;
    localparam logic [15:0] BOOT_SP = 16'hFFFE;
    localparam logic [15:0] BOOT_PC = 16'h0100;

endpackage

// File: rtl/gb_cpu_reg16_counter.sv
// gb_cpu_reg16_counter: 16-bit register with per-byte load and inc/dec, loads beating counting
// Ports: clk, reset (sync, active-high, loads RST_VAL); ld_hi/ld_lo byte loads from d;
//        inc/dec modulo-2^16 step (both together hold); q current value.
module gb_cpu_reg16_counter #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_hi,
    input  logic        ld_lo,
    input  logic [15:0] d,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] q
);
    logic [15:0] nxt;

    // Any byte load drops the count entirely, so an untouched byte holds rather than steps
    always_comb begin
        nxt = (ld_hi || ld_lo) ? {ld_hi ? d[15:8] : q[15:8], ld_lo ? d[7:0] : q[7:0]} :
              (inc && !dec)    ? q + 16'd1 :
              (dec && !inc)    ? q - 16'd1 : q;
    end

    always_ff @(posedge clk) begin
        q <= reset ? RST_VAL : nxt;
    end
endmodule

// File: rtl/gb_cpu_regfile.sv
// gb_cpu_regfile: Game Boy CPU architectural register file (A F B C D E H L SP PC)
// Ports: clk, reset (sync, active-high, loads BOOT_SKIP state);
//        rd_a/rd_b 8-bit reads, rd16 pair read (6/7 read 0);
//        wr8, wr16 (6/7 ignored), flags_we/flags_in masked flag writes, flags_out;
//        pc_inc, hl_inc/dec, sp_inc/dec counters; pc_out, sp_out.
// Option: GB_CPU_REGFILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module gb_cpu_regfile
    import gb_cpu_common_pkg::*;
#(
    parameter bit BOOT_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rd_a_sel,
    input  logic [2:0]  rd_b_sel,
    output logic [7:0]  rd_a_data,
    output logic [7:0]  rd_b_data,
    input  logic [2:0]  rd16_sel,
    output logic [15:0] rd16_data,
    input  logic        wr8_en,
    input  logic [2:0]  wr8_sel,
    input  logic [7:0]  wr8_data,
    input  logic        wr16_en,
    input  logic [2:0]  wr16_sel,
    input  logic [15:0] wr16_data,
    input  logic [3:0]  flags_we,
    input  alu_flags_t  flags_in,
    output alu_flags_t  flags_out,
    input  logic        pc_inc,
    input  logic        hl_inc,
    input  logic        hl_dec,
    input  logic        sp_inc,
    input  logic        sp_dec,
    output logic [15:0] pc_out,
    output logic [15:0] sp_out
);
`ifdef GB_CPU_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [7:0] RA = BOOT_SKIP ? BOOT_A : 8'h00;
    localparam logic [7:0] RF = BOOT_SKIP ? BOOT_F : 8'h00;
    localparam logic [7:0] RB = BOOT_SKIP ? BOOT_B : 8'h00;
    localparam logic [7:0] RC = BOOT_SKIP ? BOOT_C : 8'h00;
    localparam logic [7:0] RD = BOOT_SKIP ? BOOT_D : 8'h00;
    localparam logic [7:0] RE = BOOT_SKIP ? BOOT_E : 8'h00;
    localparam logic [15:0] RHL = BOOT_SKIP ? {BOOT_H, BOOT_L} : 16'h0000;
    localparam logic [15:0] RSP = BOOT_SKIP ? BOOT_SP : 16'h0000;
    localparam logic [15:0] RPC = BOOT_SKIP ? BOOT_PC : 16'h0000;

    logic [7:0]  a, b, c, d, e;
    logic [3:0]  f_hi;
    logic [15:0] hl, sp, pc;
    logic [7:0]  cur [8];
    logic [7:0]  wv  [8];
    logic [7:0]  vw  [8];
    logic [7:0]  f_base;
    logic        wr_sp, wr_pc, ld_h, ld_l;

    // wr8 beats wr16 on a byte; hi selects which half of wr16_data lands in this byte
    function automatic logic [7:0] merge(input logic [7:0] cv, input logic [2:0] i,
                                         input logic [2:0] p, input logic hi);
        return (wr8_en && wr8_sel == i)  ? wr8_data :
               (wr16_en && wr16_sel == p) ? (hi ? wr16_data[15:8] : wr16_data[7:0]) : cv;
    endfunction

    always_comb begin
        cur[0] = b;
        cur[1] = c;
        cur[2] = d;
        cur[3] = e;
        cur[4] = hl[15:8];
        cur[5] = hl[7:0];
        cur[6] = {f_hi, 4'h0};
        cur[7] = a;
        wv[0]  = merge(b, REG_B, PAIR_BC, 1'b1);
        wv[1]  = merge(c, REG_C, PAIR_BC, 1'b0);
        wv[2]  = merge(d, REG_D, PAIR_DE, 1'b1);
        wv[3]  = merge(e, REG_E, PAIR_DE, 1'b0);
        wv[4]  = merge(hl[15:8], REG_H, PAIR_HL, 1'b1);
        wv[5]  = merge(hl[7:0], REG_L, PAIR_HL, 1'b0);
        wv[7]  = merge(a, REG_A, PAIR_AF, 1'b1);
        f_base = merge(cur[6], REG_F, PAIR_AF, 1'b0);
        // masked flag bits override everything; the low nibble of F is hardwired to zero
        wv[6]  = {(flags_we & flags_in) | (~flags_we & f_base[7:4]), 4'h0};
        for (int i = 0; i < 8; i++) vw[i] = BYP ? wv[i] : cur[i];
    end

    assign wr_sp = wr16_en && wr16_sel == PAIR_SP;
    assign wr_pc = wr16_en && wr16_sel == PAIR_PC;
    assign ld_h  = (wr8_en && wr8_sel == REG_H) || (wr16_en && wr16_sel == PAIR_HL);
    assign ld_l  = (wr8_en && wr8_sel == REG_L) || (wr16_en && wr16_sel == PAIR_HL);

    always_ff @(posedge clk) begin
        a    <= reset ? RA : wv[7];
        f_hi <= reset ? RF[7:4] : wv[6][7:4];
        b    <= reset ? RB : wv[0];
        c    <= reset ? RC : wv[1];
        d    <= reset ? RD : wv[2];
        e    <= reset ? RE : wv[3];
    end

    gb_cpu_reg16_counter #(.RST_VAL(RHL)) u_hl (
        .clk(clk), .reset(reset), .ld_hi(ld_h), .ld_lo(ld_l), .d({wv[4], wv[5]}),
        .inc(hl_inc), .dec(hl_dec), .q(hl)
    );
    gb_cpu_reg16_counter #(.RST_VAL(RSP)) u_sp (
        .clk(clk), .reset(reset), .ld_hi(wr_sp), .ld_lo(wr_sp), .d(wr16_data),
        .inc(sp_inc), .dec(sp_dec), .q(sp)
    );
    gb_cpu_reg16_counter #(.RST_VAL(RPC)) u_pc (
        .clk(clk), .reset(reset), .ld_hi(wr_pc), .ld_lo(wr_pc), .d(wr16_data),
        .inc(pc_inc), .dec(1'b0), .q(pc)
    );

    assign rd_a_data = vw[rd_a_sel];
    assign rd_b_data = vw[rd_b_sel];
    assign rd16_data = rd16_sel == PAIR_BC ? {vw[0], vw[1]} :
                       rd16_sel == PAIR_DE ? {vw[2], vw[3]} :
                       rd16_sel == PAIR_HL ? {vw[4], vw[5]} :
                       rd16_sel == PAIR_SP ? ((BYP && wr_sp) ? wr16_data : sp) :
                       rd16_sel == PAIR_AF ? {vw[7], vw[6]} :
                       rd16_sel == PAIR_PC ? ((BYP && wr_pc) ? wr16_data : pc) : 16'h0000;
    assign flags_out = alu_flags_t'(f_hi);
    assign pc_out    = pc;
    assign sp_out    = sp;
endmodule

// File: tb/tb_gb_cpu_regfile.sv
// tb_gb_cpu_regfile: directed literal checks plus randomized cycles against a behavioural model
module tb_gb_cpu_regfile;
    import gb_cpu_common_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  rd_a_sel, rd_b_sel, rd16_sel, wr8_sel, wr16_sel;
    logic        wr8_en, wr16_en, pc_inc, hl_inc, hl_dec, sp_inc, sp_dec;
    logic [7:0]  wr8_data;
    logic [15:0] wr16_data;
    logic [3:0]  flags_we;
    alu_flags_t  flags_in;
    logic [7:0]  rda [2], rdb [2];
    logic [15:0] rd16 [2], pco [2], spo [2];
    alu_flags_t  flo [2];

    gb_cpu_regfile #(.BOOT_SKIP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
        .rd_a_data(rda[0]), .rd_b_data(rdb[0]), .rd16_sel(rd16_sel), .rd16_data(rd16[0]),
        .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data), .wr16_en(wr16_en),
        .wr16_sel(wr16_sel), .wr16_data(wr16_data), .flags_we(flags_we), .flags_in(flags_in),
        .flags_out(flo[0]), .pc_inc(pc_inc), .hl_inc(hl_inc), .hl_dec(hl_dec),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .pc_out(pco[0]), .sp_out(spo[0])
    );
    gb_cpu_regfile #(.BOOT_SKIP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
        .rd_a_data(rda[1]), .rd_b_data(rdb[1]), .rd16_sel(rd16_sel), .rd16_data(rd16[1]),
        .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data), .wr16_en(wr16_en),
        .wr16_sel(wr16_sel), .wr16_data(wr16_data), .flags_we(flags_we), .flags_in(flags_in),
        .flags_out(flo[1]), .pc_inc(pc_inc), .hl_inc(hl_inc), .hl_dec(hl_dec),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .pc_out(pco[1]), .sp_out(spo[1])
    );

    // Model: bytes indexed B,C,D,E,H,L,F,A plus SP and PC, per instance (0: zero reset, 1: boot)
    localparam logic [7:0] BOOT8 [8] = '{8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D, 8'hB0, 8'h01};
    logic [7:0]  mr [2][8];
    logic [15:0] msp [2], mpc [2];
    logic        mvalid = 1'b0;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m16(input int k, input logic [2:0] s);
        case (s)
            3'd0: return {mr[k][0], mr[k][1]};
            3'd1: return {mr[k][2], mr[k][3]};
            3'd2: return {mr[k][4], mr[k][5]};
            3'd3: return msp[k];
            3'd4: return {mr[k][7], mr[k][6]};
            3'd5: return mpc[k];
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) mr[k][i] = k == 1 ? BOOT8[i] : 8'h00;
                msp[k] = k == 1 ? 16'hFFFE : 16'h0000;
                mpc[k] = k == 1 ? 16'h0100 : 16'h0000;
            end else begin
                logic [15:0] hl;
                logic        hl_hit;
                hl = {mr[k][4], mr[k][5]};
                hl_hit = (wr8_en && (wr8_sel == 3'd4 || wr8_sel == 3'd5)) || (wr16_en && wr16_sel == 3'd2);
                if (!hl_hit && hl_inc != hl_dec) hl = hl_inc ? hl + 16'd1 : hl - 16'd1;
                {mr[k][4], mr[k][5]} = hl;
                if (!(wr16_en && wr16_sel == 3'd3) && sp_inc != sp_dec)
                    msp[k] = sp_inc ? msp[k] + 16'd1 : msp[k] - 16'd1;
                if (!(wr16_en && wr16_sel == 3'd5) && pc_inc) mpc[k] = mpc[k] + 16'd1;
                if (wr16_en)
                    case (wr16_sel)
                        3'd0: {mr[k][0], mr[k][1]} = wr16_data;
                        3'd1: {mr[k][2], mr[k][3]} = wr16_data;
                        3'd2: {mr[k][4], mr[k][5]} = wr16_data;
                        3'd3: msp[k] = wr16_data;
                        3'd4: {mr[k][7], mr[k][6]} = wr16_data;
                        3'd5: mpc[k] = wr16_data;
                        default: ;
                    endcase
                if (wr8_en) mr[k][wr8_sel] = wr8_data;
                mr[k][6][3:0] = 4'h0;
                for (int j = 0; j < 4; j++) if (flags_we[j]) mr[k][6][4+j] = flags_in[j];
            end
        end
        if (reset) mvalid = 1'b1;
    end

    always @(posedge clk) begin
        #2;
        if (mvalid)
            for (int k = 0; k < 2; k++) begin
`ifndef GB_CPU_REGFILE_BYPASS_EN
                chk($sformatf("rd_a[%0d] sel%0d", k, rd_a_sel), {8'h00, rda[k]}, {8'h00, mr[k][rd_a_sel]});
                chk($sformatf("rd_b[%0d] sel%0d", k, rd_b_sel), {8'h00, rdb[k]}, {8'h00, mr[k][rd_b_sel]});
                chk($sformatf("rd16[%0d] sel%0d", k, rd16_sel), rd16[k], m16(k, rd16_sel));
`endif
                chk($sformatf("flags[%0d]", k), {12'h000, flo[k]}, {12'h000, mr[k][6][7:4]});
                chk($sformatf("pc[%0d]", k), pco[k], mpc[k]);
                chk($sformatf("sp[%0d]", k), spo[k], msp[k]);
            end
    end

    task automatic idle();
        reset = 1'b0; wr8_en = 1'b0; wr16_en = 1'b0; flags_we = 4'h0;
        pc_inc = 1'b0; hl_inc = 1'b0; hl_dec = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0;
    endtask

    task automatic w16(input logic [2:0] s, input logic [15:0] v);
        wr16_en = 1'b1; wr16_sel = s; wr16_data = v;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic lit16(input string nm, input int k, input logic [2:0] s, input logic [15:0] exp);
        rd16_sel = s;
        #1;
        chk(nm, rd16[k], exp);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        rd_a_sel = 3'd0; rd_b_sel = 3'd0; rd16_sel = 3'd0; wr8_sel = 3'd0; wr16_sel = 3'd0;
        wr8_data = 8'h00; wr16_data = 16'h0000; flags_in = alu_flags_t'(4'h0);
        repeat (2) @(negedge clk);
        idle();
        #1;
        lit16("boot AF", 1, 3'd4, 16'h01B0);
        lit16("boot BC", 1, 3'd0, 16'h0013);
        lit16("boot DE", 1, 3'd1, 16'h00D8);
        lit16("boot HL", 1, 3'd2, 16'h014D);
        lit16("boot SP", 1, 3'd3, 16'hFFFE);
        lit16("boot PC", 1, 3'd5, 16'h0100);
        for (int s = 0; s < 8; s++) lit16($sformatf("zero pair%0d", s), 0, 3'(s), 16'h0000);
        w16(3'd4, 16'h12FF);
        next_cycle();
        lit16("AF low nibble", 1, 3'd4, 16'h12F0);
        flags_we = 4'b1000; flags_in = alu_flags_t'(4'b0111);
        next_cycle();
        lit16("Z only cleared", 1, 3'd4, 16'h1270);
        w16(3'd2, 16'hABCD); wr8_en = 1'b1; wr8_sel = 3'd5; wr8_data = 8'h11;
        next_cycle();
        lit16("HL wr16+wr8 L", 1, 3'd2, 16'hAB11);
        hl_inc = 1'b1;
        next_cycle();
        lit16("HL inc", 1, 3'd2, 16'hAB12);
        w16(3'd3, 16'h0000);
        next_cycle();
        sp_dec = 1'b1;
        next_cycle();
        lit16("SP wrap down", 1, 3'd3, 16'hFFFF);
        w16(3'd2, 16'hFFFF);
        next_cycle();
        hl_inc = 1'b1;
        next_cycle();
        lit16("HL wrap up", 1, 3'd2, 16'h0000);
        hl_inc = 1'b1; hl_dec = 1'b1;
        next_cycle();
        lit16("HL inc+dec hold", 1, 3'd2, 16'h0000);
        w16(3'd5, 16'h1234);
        next_cycle();
        w16(3'd5, 16'h0038); pc_inc = 1'b1;
        next_cycle();
        lit16("PC load beats inc", 1, 3'd5, 16'h0038);
        w16(3'd6, 16'hDEAD);
        next_cycle();
        lit16("reserved rd16", 1, 3'd6, 16'h0000);
        reset = 1'b1; wr8_en = 1'b1; wr8_sel = 3'd7; wr8_data = 8'h55;
        next_cycle();
        rd_a_sel = 3'd7;
        #1;
        chk("reset beats wr8 A boot", {8'h00, rda[1]}, 16'h0001);
        chk("reset beats wr8 A zero", {8'h00, rda[0]}, 16'h0000);
        wr8_en = 1'b1; wr8_sel = 3'd0; wr8_data = 8'h3C; rd_a_sel = 3'd0;
        #1;
`ifdef GB_CPU_REGFILE_BYPASS_EN
        chk("B same cycle", {8'h00, rda[1]}, 16'h003C);
`else
        chk("B same cycle", {8'h00, rda[1]}, 16'h0000);
`endif
        next_cycle();
        rd_a_sel = 3'd0;
        #1;
        chk("B next cycle", {8'h00, rda[1]}, 16'h003C);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset     = $urandom_range(0, 63) == 0;
            rd_a_sel  = 3'($urandom_range(0, 7));
            rd_b_sel  = 3'($urandom_range(0, 7));
            rd16_sel  = 3'($urandom_range(0, 7));
            wr8_en    = $urandom_range(0, 2) == 0;
            wr8_sel   = 3'($urandom_range(0, 7));
            wr8_data  = 8'($urandom);
            wr16_en   = $urandom_range(0, 2) == 0;
            wr16_sel  = 3'($urandom_range(0, 7));
            wr16_data = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom);
            flags_we  = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
            flags_in  = alu_flags_t'(4'($urandom_range(0, 15)));
            pc_inc    = 1'($urandom_range(0, 1));
            hl_inc    = 1'($urandom_range(0, 1));
            hl_dec    = 1'($urandom_range(0, 1));
            sp_inc    = 1'($urandom_range(0, 1));
            sp_dec    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
